// File: rtl/psram_pkg.sv
// ---------------------------------------------------------------------------
// psram_pkg
// Shared definitions for the psram cache and the psram controller:
//   - state_e      : cache sequencer states (IDLE / MEM / DONE)
//   - SEL_*        : the four legal Wishbone byte-enable patterns
//   - tag_width()  : tag width for a given number of index bits
// ---------------------------------------------------------------------------
package psram_pkg;

    localparam int ADDR_W = 22;   // halfword address width of the psram bus

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [3:0] SEL_BYTE = 4'b0001;
    localparam logic [3:0] SEL_HALF = 4'b0011;
    localparam logic [3:0] SEL_3B   = 4'b0111;
    localparam logic [3:0] SEL_WORD = 4'b1111;

    // Address = {tag, index, halfword-select bit}.
    function automatic int tag_width(input int index_bits);
        return ADDR_W - index_bits - 1;
    endfunction

endpackage

// File: rtl/psram_cache_mem.sv
// ---------------------------------------------------------------------------
// psram_cache_mem
// Tag / data / valid storage for the direct-mapped cache.
//   clk_i, rst_ni         : clock, async active-low reset (clears valid only)
//   rd_idx                : lookup index; rd_valid/rd_tag/rd_data read async
//   wr_en, wr_idx, wr_tag : write tag and the byte lanes selected by wr_be
//   wr_data, wr_be        : line data and byte mask
//   set_valid, clr_valid  : mark line wr_idx valid / invalid
//   flush_i               : invalidate every line; wins over set_valid
// ---------------------------------------------------------------------------
module psram_cache_mem
    import psram_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int TAG_W      = tag_width(INDEX_BITS)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic                  rd_valid,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [31:0]           rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [31:0]           wr_data,
    input  logic [3:0]            wr_be,
    input  logic                  set_valid,
    input  logic                  clr_valid,
    input  logic                  flush_i
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];
    logic [LINES-1:0] valid_q;

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];

    // NOTE: tag/data arrays are deliberately not reset; the valid bits alone
    // decide whether a line's contents mean anything, so they can map to RAM.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            tag_mem[wr_idx] <= wr_tag;
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    data_mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (set_valid) begin
            valid_q[wr_idx] <= 1'b1;
        end else if (clr_valid) begin
            valid_q[wr_idx] <= 1'b0;
        end
    end

endmodule

// File: rtl/psram_cache.sv
// ---------------------------------------------------------------------------
// psram_cache
// Direct-mapped, write-through, one-word-per-line read cache between the CPU
// Wishbone bus and the psram controller.
//   clk_i, rst_ni        : clock, async active-low reset
//   s_*                  : upstream Wishbone slave (halfword address)
//   m_*                  : downstream Wishbone master to the psram controller
//   flush_i              : synchronous invalidate-all pulse
//   hit_count_o          : saturating read-hit counter
//   miss_count_o         : saturating read-miss counter (even reads only)
// Odd halfword addresses bypass the cache entirely.
// ---------------------------------------------------------------------------
module psram_cache
    import psram_pkg::*;
#(
    parameter int INDEX_BITS    = 6,
    parameter int CLK_PERIOD_NS = 20
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        s_stb_i,
    input  logic        s_cyc_i,
    input  logic [3:0]  s_sel_i,
    input  logic        s_we_i,
    input  logic [21:0] s_addr_i,
    input  logic [31:0] s_data_i,
    output logic        s_ack_o,
    output logic [31:0] s_data_o,
    output logic        m_stb_o,
    output logic        m_cyc_o,
    output logic [3:0]  m_sel_o,
    output logic        m_we_o,
    output logic [21:0] m_addr_o,
    output logic [31:0] m_data_o,
    input  logic        m_ack_i,
    input  logic [31:0] m_data_i,
    input  logic        flush_i,
    output logic [31:0] hit_count_o,
    output logic [31:0] miss_count_o
);

    localparam int TAG_W = tag_width(INDEX_BITS);

    // The clock period only documents the intended operating point.
    if (CLK_PERIOD_NS < 1) begin : g_bad_period
        $error("psram_cache: CLK_PERIOD_NS must be positive");
    end

    state_e state_q, state_d;
    logic   ack_q;
    logic   abort_q;   // upstream dropped s_stb_i while the access was in flight

    // Lookup uses the live request in IDLE and the latched request afterwards.
    logic [INDEX_BITS-1:0] lk_idx;
    logic [TAG_W-1:0]      lk_tag;
    logic                  rd_valid;
    logic [TAG_W-1:0]      rd_tag;
    logic [31:0]           rd_data;
    logic                  lk_match;

    assign lk_idx   = (state_q == IDLE) ? s_addr_i[INDEX_BITS:1] : m_addr_o[INDEX_BITS:1];
    assign lk_tag   = (state_q == IDLE) ? s_addr_i[21:INDEX_BITS+1] : m_addr_o[21:INDEX_BITS+1];
    assign lk_match = rd_valid && (rd_tag == lk_tag);

    logic req, read_hit, issue, mem_done, aborting, fill, wr_hit;

    assign req      = s_stb_i && s_cyc_i && !ack_q;
    assign read_hit = (state_q == IDLE) && req && !s_we_i && !s_addr_i[0] && lk_match;
    assign issue    = (state_q == IDLE) && req && !read_hit;
    assign mem_done = (state_q == MEM) && m_ack_i;
    assign aborting = abort_q || !s_stb_i;
    assign fill     = mem_done && !m_we_o && !m_addr_o[0];
    assign wr_hit   = mem_done && m_we_o && !m_addr_o[0] && lk_match;

    assign s_ack_o  = ack_q && s_stb_i;

    // ---------------- state register ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    // NOTE: every combinational output gets a default first, so no path
    // through the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (read_hit)   state_d = DONE;
                else if (issue) state_d = MEM;
            end
            MEM: begin
                if (m_ack_i) state_d = aborting ? IDLE : DONE;
            end
            DONE: begin
                if (!s_stb_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- cache-update outputs ----------------
    logic        wr_en, set_valid, clr_valid;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;

    always_comb begin
        wr_en     = 1'b0;
        wr_be     = 4'b0000;
        wr_data   = m_data_o;
        set_valid = 1'b0;
        clr_valid = 1'b0;
        if (fill) begin
            wr_en     = 1'b1;
            wr_be     = SEL_WORD;
            wr_data   = m_data_i;
            set_valid = 1'b1;
        end else if (wr_hit) begin
            unique case (m_sel_o)
                SEL_WORD: begin wr_en = 1'b1; wr_be = SEL_WORD; end
                SEL_BYTE: begin wr_en = 1'b1; wr_be = SEL_BYTE; end
                SEL_HALF: begin wr_en = 1'b1; wr_be = SEL_HALF; end
                // The controller stores only the low halfword for 0111, so the
                // line no longer matches memory in any predictable way.
                default:  clr_valid = 1'b1;
            endcase
        end
    end

    psram_cache_mem #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_W      (TAG_W)
    ) u_mem (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .rd_idx    (lk_idx),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_idx    (m_addr_o[INDEX_BITS:1]),
        .wr_tag    (m_addr_o[21:INDEX_BITS+1]),
        .wr_data   (wr_data),
        .wr_be     (wr_be),
        .set_valid (set_valid),
        .clr_valid (clr_valid),
        .flush_i   (flush_i)
    );

    // ---------------- bus and counter registers ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_q        <= 1'b0;
            abort_q      <= 1'b0;
            s_data_o     <= '0;
            m_stb_o      <= 1'b0;
            m_cyc_o      <= 1'b0;
            m_sel_o      <= '0;
            m_we_o       <= 1'b0;
            m_addr_o     <= '0;
            m_data_o     <= '0;
            hit_count_o  <= '0;
            miss_count_o <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (read_hit) begin
                        s_data_o <= rd_data;
                        ack_q    <= 1'b1;
                        if (hit_count_o != '1) hit_count_o <= hit_count_o + 32'd1;
                    end else if (issue) begin
                        m_stb_o  <= 1'b1;
                        m_cyc_o  <= 1'b1;
                        m_we_o   <= s_we_i;
                        // Reads always fetch the full word so the line can be filled.
                        m_sel_o  <= s_we_i ? s_sel_i : SEL_WORD;
                        m_addr_o <= s_addr_i;
                        m_data_o <= s_data_i;
                        abort_q  <= 1'b0;
                    end
                end
                MEM: begin
                    if (!s_stb_i) abort_q <= 1'b1;
                    if (m_ack_i) begin
                        m_stb_o <= 1'b0;
                        m_cyc_o <= 1'b0;
                        ack_q   <= !aborting;
                        if (!m_we_o) s_data_o <= m_data_i;
                        if (fill && miss_count_o != '1) miss_count_o <= miss_count_o + 32'd1;
                    end
                end
                DONE: begin
                    if (!s_stb_i) ack_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_psram_cache.sv
// ---------------------------------------------------------------------------
// tb_psram_cache
// Directed plus randomized checks of psram_cache against a behavioural model:
// the cache is modelled as a map from cached even address to word, where a
// fill evicts whichever address shares its line; psram is a sparse word map.
// ---------------------------------------------------------------------------
module tb_psram_cache;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        s_stb_i, s_cyc_i, s_we_i;
    logic [3:0]  s_sel_i;
    logic [21:0] s_addr_i;
    logic [31:0] s_data_i;
    logic        s_ack_o;
    logic [31:0] s_data_o;
    logic        m_stb_o, m_cyc_o, m_we_o;
    logic [3:0]  m_sel_o;
    logic [21:0] m_addr_o;
    logic [31:0] m_data_o;
    logic        m_ack_i;
    logic [31:0] m_data_i;
    logic        flush_i;
    logic [31:0] hit_count_o, miss_count_o;

    psram_cache #(.INDEX_BITS(6), .CLK_PERIOD_NS(20)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .s_stb_i      (s_stb_i),
        .s_cyc_i      (s_cyc_i),
        .s_sel_i      (s_sel_i),
        .s_we_i       (s_we_i),
        .s_addr_i     (s_addr_i),
        .s_data_i     (s_data_i),
        .s_ack_o      (s_ack_o),
        .s_data_o     (s_data_o),
        .m_stb_o      (m_stb_o),
        .m_cyc_o      (m_cyc_o),
        .m_sel_o      (m_sel_o),
        .m_we_o       (m_we_o),
        .m_addr_o     (m_addr_o),
        .m_data_o     (m_data_o),
        .m_ack_i      (m_ack_i),
        .m_data_i     (m_data_i),
        .flush_i      (flush_i),
        .hit_count_o  (hit_count_o),
        .miss_count_o (miss_count_o)
    );

    always #10 clk_i = ~clk_i;

    int pass_count = 0;
    int total      = 0;
    int fail_count = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_count++;
        else begin
            fail_count++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- psram model ----------------
    logic [31:0] pmem [int unsigned];

    function automatic logic [31:0] psram_word(input logic [21:0] a);
        if (pmem.exists(int'(a))) return pmem[int'(a)];
        return {10'h2B5, a} ^ 32'h1357_9BDF;
    endfunction

    // Byte merge as the controller performs it (0111 stores the low halfword).
    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] sel);
        case (sel)
            4'b0001: return {old_w[31:8], new_w[7:0]};
            4'b0011: return {old_w[31:16], new_w[15:0]};
            4'b0111: return {old_w[31:16], new_w[15:0]};
            default: return new_w;
        endcase
    endfunction

    bit          hold_ack = 1'b0;
    int          down_count = 0;
    int          wait_cnt = 0;
    logic [21:0] last_addr;
    logic [3:0]  last_sel;
    logic        last_we;
    logic [31:0] last_wdata;

    initial begin
        m_ack_i  = 1'b0;
        m_data_i = '0;
        forever begin
            @(negedge clk_i);
            if (m_ack_i) begin
                m_ack_i = 1'b0;
            end else if (hold_ack) begin
                wait_cnt = 0;
            end else if (m_stb_o && m_cyc_o) begin
                if (wait_cnt == 0) begin
                    down_count++;
                    last_addr  = m_addr_o;
                    last_sel   = m_sel_o;
                    last_we    = m_we_o;
                    last_wdata = m_data_o;
                    if (m_we_o) begin
                        pmem[int'(m_addr_o)] = merge(psram_word(m_addr_o), m_data_o, m_sel_o);
                        m_data_i = $urandom;
                    end else begin
                        m_data_i = psram_word(m_addr_o);
                    end
                    m_ack_i  = 1'b1;
                    wait_cnt = $urandom_range(0, 3);
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    // ---------------- cache model ----------------
    logic [31:0] mcache [int unsigned];
    int          m_hits = 0;
    int          m_misses = 0;

    function automatic int line_of(input int unsigned a);
        return (a >> 1) % 64;
    endfunction

    task automatic model_fill(input logic [21:0] a, input logic [31:0] d);
        int unsigned victims[$];
        foreach (mcache[k]) if (line_of(k) == line_of(int'(a))) victims.push_back(k);
        foreach (victims[i]) mcache.delete(victims[i]);
        mcache[int'(a)] = d;
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic check_counters(input string tag);
        check({tag, "_hits"}, hit_count_o, m_hits);
        check({tag, "_misses"}, miss_count_o, m_misses);
    endtask

    task automatic do_read(input logic [21:0] a);
        bit          exp_hit  = !a[0] && mcache.exists(int'(a));
        logic [31:0] exp_data = exp_hit ? mcache[int'(a)] : psram_word(a);
        int          d0  = down_count;
        int          cyc = 0;
        bit          got = 0;
        s_addr_i = a; s_we_i = 1'b0; s_sel_i = 4'b1111; s_data_i = $urandom;
        s_stb_i  = 1'b1; s_cyc_i = 1'b1;
        #1 check("rd_early_ack", s_ack_o, 0);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_i); #1; cyc++;
            if (s_ack_o) begin got = 1; break; end
        end
        check("rd_ack", got, 1);
        check("rd_data", s_data_o, exp_data);
        if (exp_hit) check("hit_latency", cyc, 1);
        check("rd_downstream", down_count - d0, exp_hit ? 0 : 1);
        if (!exp_hit) begin
            check("rd_m_sel", last_sel, 4'b1111);
            check("rd_m_addr", last_addr, a);
        end
        if (!a[0]) begin
            if (exp_hit) m_hits++;
            else begin m_misses++; model_fill(a, exp_data); end
        end
        s_stb_i = 1'b0; s_cyc_i = 1'b0;
        @(posedge clk_i); #1;
        check_counters("rd");
    endtask

    task automatic do_write(input logic [21:0] a, input logic [3:0] sel, input logic [31:0] d);
        int d0 = down_count;
        bit got = 0;
        s_addr_i = a; s_we_i = 1'b1; s_sel_i = sel; s_data_i = d;
        s_stb_i  = 1'b1; s_cyc_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_i); #1;
            if (s_ack_o) begin got = 1; break; end
        end
        check("wr_ack", got, 1);
        check("wr_downstream", down_count - d0, 1);
        check("wr_m_sel", last_sel, sel);
        check("wr_m_addr", last_addr, a);
        check("wr_m_data", last_wdata, d);
        check("wr_m_we", last_we, 1);
        if (!a[0] && mcache.exists(int'(a))) begin
            if (sel == 4'b0111) mcache.delete(int'(a));
            else mcache[int'(a)] = merge(mcache[int'(a)], d, sel);
        end
        s_stb_i = 1'b0; s_cyc_i = 1'b0; s_we_i = 1'b0;
        @(posedge clk_i); #1;
        check_counters("wr");
    endtask

    task automatic do_flush();
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        mcache.delete();
    endtask

    task automatic wait_m_stb(input logic level, input string tag);
        bit seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (m_stb_o === level) begin seen = 1; break; end
            @(posedge clk_i); #1;
        end
        check(tag, seen, 1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0;
        s_stb_i = 0; s_cyc_i = 0; s_we_i = 0; s_sel_i = 0; s_addr_i = 0; s_data_i = 0;
        flush_i = 0;
        pmem[32'h10] = 32'hDEAD_BEEF;
        #5;
        check("rst_s_ack", s_ack_o, 0);
        check("rst_m_stb", m_stb_o, 0);
        check("rst_m_cyc", m_cyc_o, 0);
        check("rst_m_we", m_we_o, 0);
        check("rst_m_sel", m_sel_o, 0);
        check("rst_m_addr", m_addr_o, 0);
        check("rst_m_data", m_data_o, 0);
        check("rst_s_data", s_data_o, 0);
        check_counters("rst");
        @(negedge clk_i) rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Cold miss then hit.
        do_read(22'h10);
        check("first_fill", s_data_o, 32'hDEAD_BEEF);
        do_read(22'h10);
        // Byte write to a cached line.
        do_write(22'h10, 4'b0001, 32'h0000_00AA);
        do_read(22'h10);
        check("byte_merge", s_data_o, 32'hDEAD_BEAA);
        // 0111 write invalidates.
        do_write(22'h10, 4'b0111, 32'h1234_5678);
        do_read(22'h10);
        // Alias on the same line.
        do_read(22'h90);
        do_read(22'h10);
        // Odd addresses bypass.
        do_read(22'h11);
        do_read(22'h11);
        // Flush after fill.
        do_read(22'h10);
        do_flush();
        do_read(22'h10);

        // Reset during MEM: outputs drop at once, valid bits clear.
        hold_ack = 1'b1;
        s_addr_i = 22'h200; s_we_i = 0; s_sel_i = 4'b1111; s_stb_i = 1; s_cyc_i = 1;
        wait_m_stb(1'b1, "rst_mem_issue");
        rst_ni = 1'b0;
        #1;
        check("rstmid_m_stb", m_stb_o, 0);
        check("rstmid_m_cyc", m_cyc_o, 0);
        check("rstmid_s_ack", s_ack_o, 0);
        m_hits = 0; m_misses = 0; mcache.delete();
        check_counters("rstmid");
        s_stb_i = 0; s_cyc_i = 0;
        @(negedge clk_i) rst_ni = 1'b1;
        hold_ack = 1'b0;
        @(posedge clk_i); #1;
        do_read(22'h10);

        // Strobe dropped mid-access: cache updated, no ack.
        hold_ack = 1'b1;
        s_addr_i = 22'h300; s_we_i = 0; s_sel_i = 4'b1111; s_stb_i = 1; s_cyc_i = 1;
        wait_m_stb(1'b1, "abort_issue");
        @(posedge clk_i); #1;
        s_stb_i = 0; s_cyc_i = 0;
        hold_ack = 1'b0;
        wait_m_stb(1'b0, "abort_complete");
        m_misses++; model_fill(22'h300, psram_word(22'h300));
        check("abort_misses", miss_count_o, m_misses);
        do_read(22'h300);

        // Randomized traffic over a few aliasing lines.
        for (int n = 0; n < 150; n++) begin
            logic [21:0] a;
            int          op;
            logic [3:0]  sel;
            a  = 22'(($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 1));
            if ($urandom_range(0, 5) == 0) a[0] = 1'b1;
            op = $urandom_range(0, 9);
            if (op < 6) do_read(a);
            else if (op < 9) begin
                case ($urandom_range(0, 3))
                    0: sel = 4'b0001;
                    1: sel = 4'b0011;
                    2: sel = 4'b0111;
                    default: sel = 4'b1111;
                endcase
                do_write(a, sel, $urandom);
            end else do_flush();
        end

        $display("%0d/%0d checks passed", pass_count, total);
        $finish;
    end

endmodule

// File: doc/psram_cache.md
Name: psram_cache

Overview:
Direct-mapped, write-through, single-word-line read cache. It sits between the CPU data/instruction Wishbone bus and the psram controller. Upstream it is a Wishbone slave; downstream it is a Wishbone master onto the psram controller. Hits on 32-bit words return in one cycle instead of a full PSRAM read (two ~70 ns halfword accesses).

Parameters:
INDEX_BITS, 6, log2 of number of lines (64 lines of 32 bits each)
CLK_PERIOD_NS, 20, informational only; forwarded for consistency with the psram controller, no logic depends on it

Ports:
clk_i  in  1  clock; everything is sampled on the rising edge
rst_ni  in  1  asynchronous, active-low reset
s_stb_i  in  1  upstream strobe
s_cyc_i  in  1  upstream cycle
s_sel_i  in  4  byte enables: 0001, 0011, 0111 or 1111
s_we_i  in  1  1 = write, 0 = read
s_addr_i  in  22  halfword address
s_data_i  in  32  write data
s_ack_o  out  1  upstream ack
s_data_o  out  32  read data
m_stb_o  out  1  to psram stb_i
m_cyc_o  out  1  to psram cyc_i
m_sel_o  out  4  to psram sel_i
m_we_o  out  1  to psram we_i
m_addr_o  out  22  to psram addr_i
m_data_o  out  32  to psram data_i
m_ack_i  in  1  from psram ack_o
m_data_i  in  32  from psram data_o
flush_i  in  1  synchronous invalidate-all pulse
hit_count_o  out  32  saturating read-hit counter
miss_count_o  out  32  saturating read-miss counter

Behaviour:
- Reset (async, rst_ni=0):
  - all valid bits cleared; state IDLE.
  - s_ack_o=0, m_stb_o=0, m_cyc_o=0, m_we_o=0, m_sel_o=0, m_addr_o=0, m_data_o=0, s_data_o=0, both counters 0.
  - Reset mid-transaction abandons it; no ack is generated.
- Address split for even addresses:
  - index = s_addr_i[INDEX_BITS:1]
  - tag = s_addr_i[21:INDEX_BITS+1]
  - hit = valid[index] & tag match & s_addr_i[0]==0 & ~s_we_i.
- Odd-address accesses are never cached: pass-through, no counter change.
- Ack style: an internal ack_q register; s_ack_o = ack_q & s_stb_i.
  - ack_q stays set until s_stb_i is sampled low.
  - A new request is accepted only when ack_q=0.
- States IDLE, MEM, DONE:
  - IDLE, read hit: accept when s_stb_i & s_cyc_i & ~ack_q. On the next edge s_data_o <= line, ack_q <= 1, hit_count_o += 1, go DONE. Latency: ack visible 1 cycle after accept.
  - IDLE, otherwise: latch s_sel/we/addr/data into m_* and assert m_stb_o=m_cyc_o=1, go MEM.
    - Read misses are issued with m_sel_o=1111 (full-word fill) regardless of s_sel_i.
    - Writes are forwarded with s_sel_i unchanged.
  - MEM: hold all m_* stable until m_ack_i=1. On that edge: m_stb_o=m_cyc_o=0, ack_q <= 1, go DONE.
    - Read: s_data_o <= m_data_i. If the address is even, write the line, set valid, set tag, miss_count_o += 1.
    - Write hit, sel 1111: replace the whole line.
    - Write hit, sel 0001: update byte 0 only.
    - Write hit, sel 0011: update bytes 0-1 only.
    - Write hit, sel 0111: invalidate the line, because the controller writes only the low halfword for this sel.
    - Write miss: no allocate.
  - DONE: when s_stb_i is sampled low, ack_q <= 0, go IDLE. This guarantees m_stb_o is low at least 1 cycle between downstream requests, as the psram controller requires.
- s_stb_i dropped during MEM (protocol violation): complete the downstream access, update the cache as normal, suppress the ack, return to IDLE.
- flush_i:
  - clears all valid bits on the next edge, in any state.
  - A fill completing in the same cycle is written but not validated.
- Counters saturate at 32'hFFFF_FFFF.

Decomposition:
- Package psram_pkg: state enum (IDLE/MEM/DONE), SEL_BYTE/SEL_HALF/SEL_3B/SEL_WORD constants, and a tag-width function of INDEX_BITS. The psram controller later imports the SEL_* constants too.
- One sub-module, psram_cache_mem: tag/data/valid array with async read, byte-masked write, and async-reset/flush clear of valid.

Test Plan:
- Read 0x000010 cold -> m_stb_o with m_sel_o=1111, m_addr_o=0x000010. Model returns 0xDEADBEEF -> s_data_o=0xDEADBEEF, miss_count_o=1. Repeat the read -> ack 1 cycle after strobe, no m_stb_o, hit_count_o=1.
- Write 0x000010, sel 0001, data 0x000000AA, after the line is cached -> forwarded with sel 0001. Then read 0x000010 -> hit returns 0xDEADBEAA.
- Write 0x000010, sel 0111 -> line invalidated. Next read -> miss, goes to memory.
- Alias: read 0x000010, then read 0x000090 (same index, INDEX_BITS=6) -> both miss. Re-read 0x000010 -> miss again.
- Odd address 0x000011 read twice -> two downstream accesses, counters unchanged.
- flush_i pulse after fill -> next read misses. Assert rst_ni=0 during MEM -> m_stb_o and s_ack_o drop immediately, valid bits clear.
